waypoint_sequencer: RTL and testbench



---
 rtl/waypoint_pkg.sv | 20 ++
 rtl/waypoint_store.sv | 29 ++
 rtl/waypoint_sequencer.sv | 153 +++++++++++++++
 tb/tb_waypoint_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/waypoint_pkg.sv
// waypoint_pkg
//   Shared types and helpers for the waypoint sequencer slice.
//   - NODE_W_DEF : default node id width (upper nibble row, lower nibble column)
//   - state_e    : sequencer FSM states (IDLE / RUN / DONE)
//   - cnt_w()    : width needed to count 0..depth inclusive
package waypoint_pkg;

    localparam int NODE_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/waypoint_store.sv
// waypoint_store
//   DEPTH x NODE_W waypoint registers, one write port, one combinational read.
//   Contents survive reset; validity is tracked by the owner's count.
// Ports:
//   clk            system clock
//   we/waddr/wdata write enable, address, data (written at posedge)
//   raddr/rdata    asynchronous read
module waypoint_store #(
    parameter int NODE_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [NODE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [NODE_W-1:0] rdata
);

    logic [NODE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/waypoint_sequencer.sv
// waypoint_sequencer
//   Loads a waypoint list over a valid/ready port, then hands the route solver
//   one source/destination leg at a time, advancing when next_node reaches the
//   current destination. Reports completion with a one-cycle mission_done.
//   Build option: define WP_LOOP_EN for patrol mode (list replays forever,
//   mission_done pulses each lap, only abort or reset leaves RUN).
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   wp_valid/wp_data/wp_ready waypoint load handshake
//   start, abort              mission control (abort wins over start/arrival)
//   current_node, next_node   AGV position feedback
//   source, destination       current leg to the route solver
//   dest_valid, busy          leg active / FSM in RUN
//   mission_done              one-cycle pulse on final arrival
//   wp_count                  number of stored waypoints
module waypoint_sequencer
    import waypoint_pkg::*;
#(
    parameter int                       NODE_W     = NODE_W_DEF,
    parameter int                       DEPTH      = 16,
    parameter logic [NODE_W-1:0]        START_NODE = 8'h60
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wp_valid,
    input  logic [NODE_W-1:0]           wp_data,
    output logic                        wp_ready,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NODE_W-1:0]           current_node,
    input  logic [NODE_W-1:0]           next_node,
    output logic [NODE_W-1:0]           source,
    output logic [NODE_W-1:0]           destination,
    output logic                        dest_valid,
    output logic                        busy,
    output logic                        mission_done,
    output logic [cnt_w(DEPTH)-1:0]     wp_count
);

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [NODE_W-1:0] src_q, src_d, dst_q, dst_d;
    logic              dv_q, dv_d, done_q, done_d;
    logic [CW-1:0]     cnt_q, cnt_d, idx_q, idx_d;

    logic              we;
    logic [AW-1:0]     raddr;
    logic [NODE_W-1:0] rdata;

    // start takes precedence over loading in the same cycle.
    assign wp_ready = rst_n && (state_q == S_IDLE) && (cnt_q < CW'(DEPTH)) && !start;
    assign we       = wp_valid && wp_ready;

    // Read list[idx] while legs remain; otherwise list[0] (first leg or patrol wrap).
    always_comb begin
        raddr = '0;
        if (state_q == S_RUN && idx_q < cnt_q) raddr = idx_q[AW-1:0];
    end

    waypoint_store #(.NODE_W(NODE_W), .DEPTH(DEPTH), .AW(AW)) u_store (
        .clk   (clk),
        .we    (we),
        .waddr (cnt_q[AW-1:0]),
        .wdata (wp_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        dv_d    = dv_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    cnt_d = '0;
                end else if (start && cnt_q != '0) begin
                    state_d = S_RUN;
                    src_d   = current_node;
                    dst_d   = rdata;
                    idx_d   = CW'(1);
                    dv_d    = 1'b1;
                end else if (we) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    dv_d    = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (next_node == dst_q) begin
                    src_d = dst_q;
                    if (idx_q < cnt_q) begin
                        dst_d = rdata;
                        idx_d = idx_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
`ifdef WP_LOOP_EN
                        dst_d = rdata;
                        idx_d = CW'(1);
`else
                        dv_d    = 1'b0;
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_DONE: begin
                // Abort here lands in the same place, so no separate branch.
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= START_NODE;
            dst_q   <= START_NODE;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign source       = src_q;
    assign destination  = dst_q;
    assign dest_valid   = dv_q;
    assign busy         = (state_q == S_RUN);
    assign mission_done = done_q;
    assign wp_count     = cnt_q;

endmodule

// File: tb/tb_waypoint_sequencer.sv
// tb_waypoint_sequencer
//   Scoreboarded bench: after every clock edge a queue-based mission model
//   pushes the expected output snapshot; a monitor pops and compares on the
//   falling edge. Directed mission scenarios are followed by random traffic.
module tb_waypoint_sequencer;

    localparam int NODE_W = 8;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam logic [7:0] IDLE_NODE = 8'hEE;

`ifdef WP_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n, wp_valid, start, abort;
    logic [NODE_W-1:0] wp_data, current_node, next_node;
    logic              wp_ready, dest_valid, busy, mission_done;
    logic [NODE_W-1:0] source, destination;
    logic [CW-1:0]     wp_count;

    always #5 clk = ~clk;

    waypoint_sequencer #(.NODE_W(NODE_W), .DEPTH(DEPTH), .START_NODE(8'h60)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wp_valid     (wp_valid),
        .wp_data      (wp_data),
        .wp_ready     (wp_ready),
        .start        (start),
        .abort        (abort),
        .current_node (current_node),
        .next_node    (next_node),
        .source       (source),
        .destination  (destination),
        .dest_valid   (dest_valid),
        .busy         (busy),
        .mission_done (mission_done),
        .wp_count     (wp_count)
    );

    typedef struct {
        logic       rdy;
        logic [7:0] src;
        logic [7:0] dst;
        logic       dv;
        logic       busy;
        logic       done;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Mission model: mode 0 = waiting for a mission, 1 = travelling, 2 = wrap-up cycle.
    int         m_mode = 0;
    logic [7:0] m_list[$];
    int         m_leg  = 0;
    logic [7:0] m_src  = 8'h60;
    logic [7:0] m_dst  = 8'h60;
    logic       m_dv   = 1'b0;
    logic       m_done = 1'b0;

    function automatic void model_step();
        if (!rst_n) begin
            m_mode = 0; m_src = 8'h60; m_dst = 8'h60; m_dv = 1'b0; m_done = 1'b0;
            m_list.delete(); m_leg = 0;
            return;
        end
        m_done = 1'b0;
        if (m_mode == 0) begin
            if (abort) m_list.delete();
            else if (start && m_list.size() > 0) begin
                m_mode = 1; m_src = current_node; m_dst = m_list[0]; m_leg = 1; m_dv = 1'b1;
            end else if (wp_valid && !start && m_list.size() < DEPTH) m_list.push_back(wp_data);
        end else if (m_mode == 1) begin
            if (abort) begin
                m_mode = 0; m_dv = 1'b0; m_list.delete(); m_leg = 0;
            end else if (next_node == m_dst) begin
                m_src = m_dst;
                if (m_leg < m_list.size()) begin
                    m_dst = m_list[m_leg]; m_leg++;
                end else if (LOOP) begin
                    m_dst = m_list[0]; m_leg = 1; m_done = 1'b1;
                end else begin
                    m_dv = 1'b0; m_done = 1'b1; m_mode = 2;
                end
            end
        end else begin
            m_mode = 0; m_list.delete(); m_leg = 0;
        end
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        e.rdy  = rst_n && (m_mode == 0) && (m_list.size() < DEPTH) && !start;
        e.src  = m_src;
        e.dst  = m_dst;
        e.dv   = m_dv;
        e.busy = (m_mode == 1);
        e.done = m_done;
        e.cnt  = m_list.size();
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (wp_ready !== e.rdy || source !== e.src || destination !== e.dst ||
                dest_valid !== e.dv || busy !== e.busy || mission_done !== e.done ||
                int'(wp_count) != e.cnt) begin
                failures++;
                $display("FAIL snapshot t=%0t got rdy=%b src=%h dst=%h dv=%b busy=%b done=%b cnt=%0d want rdy=%b src=%h dst=%h dv=%b busy=%b done=%b cnt=%0d",
                         $time, wp_ready, source, destination, dest_valid, busy, mission_done,
                         wp_count, e.rdy, e.src, e.dst, e.dv, e.busy, e.done, e.cnt);
            end
        end
    end

    task automatic load_one(input logic [7:0] d);
        wp_valid = 1'b1; wp_data = d;
        tick();
        wp_valid = 1'b0;
    endtask

    task automatic go(input logic [7:0] cur);
        current_node = cur; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic arrive(input logic [7:0] d);
        next_node = d;
        tick();
        next_node = IDLE_NODE;
    endtask

    initial begin
        rst_n = 1'b0; wp_valid = 1'b0; wp_data = '0; start = 1'b0; abort = 1'b0;
        current_node = 8'h00; next_node = IDLE_NODE;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic five-leg mission.
        load_one(8'h18); load_one(8'h68); load_one(8'h63); load_one(8'h31); load_one(8'h16);
        go(8'h60);
        tick();
        arrive(8'h18); arrive(8'h68); arrive(8'h63); arrive(8'h31); arrive(8'h16);
        tick(); tick();

        // Fill to capacity with one extra offer, then an empty-list start.
        for (int i = 0; i < DEPTH + 1; i++) load_one(8'(8'h40 + i));
        wp_valid = 1'b1; wp_data = 8'h7F; tick(); wp_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        start = 1'b1; tick(); tick(); start = 1'b0;
        tick();

        // Abort coincident with arrival.
        load_one(8'h18); load_one(8'h68); load_one(8'h63);
        go(8'h60);
        arrive(8'h18);
        next_node = 8'h68; abort = 1'b1; tick(); abort = 1'b0; next_node = IDLE_NODE;
        tick();

        // Duplicate consecutive waypoints.
        load_one(8'h22); load_one(8'h22); load_one(8'h45);
        go(8'h60);
        next_node = 8'h22; tick(); tick(); next_node = IDLE_NODE;
        arrive(8'h45);
        tick(); tick();

        // Two-point patrol (plain completion when looping is not built in), then reset mid-run.
        load_one(8'h18); load_one(8'h68);
        go(8'h60);
        arrive(8'h18); arrive(8'h68); arrive(8'h18); arrive(8'h68); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            abort        = ($urandom_range(0, 99) < 3);
            start        = ($urandom_range(0, 99) < 12);
            wp_valid     = $urandom_range(0, 1);
            wp_data      = 8'($urandom_range(0, 127));
            current_node = 8'($urandom_range(0, 127));
            next_node    = (m_dv && $urandom_range(0, 99) < 50) ? m_dst : 8'($urandom_range(0, 127));
            tick();
        end
        abort = 1'b0; start = 1'b0; wp_valid = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected snapshots never compared, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
